// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: FSM state encoding and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode != PAR_NONE) && (mode != PAR_NONE_ALT);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receive path: input synchroniser, start-bit validation and mid-bit sampling.
//   state  | meaning
//   IDLE   | waiting for a synchronised falling edge
//   START  | confirm start bit at half a bit period
//   DATA   | sample DATA_W bits, LSB first
//   PARITY | sample parity bit
//   STOP   | sample stop bit, deliver frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [1:0]        parity_mode,
    input  logic              rx_uart,
    output logic              restart,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_busy
);
    localparam int OVS_W = $clog2(OVS);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              sync1_q, sync2_q, prev_q;
    uart_state_e       state_q, state_d;
    logic [OVS_W-1:0]  ovs_q, ovs_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_rx_q, par_rx_d;
    logic              par_en_q, par_en_d;
    logic              par_odd_q, par_odd_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;

    always_comb begin
        state_d   = state_q;
        ovs_d     = ovs_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_rx_d  = par_rx_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        restart   = 1'b0;
        if (state_q == IDLE) begin
            // prev_q must be high, so after a low stop bit the line has to recover first
            if (prev_q && !sync2_q) begin
                state_d   = START;
                ovs_d     = OVS_W'(OVS / 2 - 1);
                restart   = 1'b1;
                par_en_d  = par_enabled(parity_mode);
                par_odd_d = (parity_mode == PAR_ODD);
            end
        end else if (tick) begin
            if (ovs_q != '0) begin
                ovs_d = ovs_q - 1'b1;
            end else begin
                ovs_d = OVS_W'(OVS - 1);
                case (state_q)
                    START: begin
                        if (sync2_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            bit_d   = BIT_W'(DATA_W - 1);
                        end
                    end
                    DATA: begin
                        shift_d = {sync2_q, shift_q[DATA_W-1:1]};
                        if (bit_q != '0) bit_d = bit_q - 1'b1;
                        else state_d = par_en_q ? PARITY : STOP;
                    end
                    PARITY: begin
                        par_rx_d = sync2_q;
                        state_d  = STOP;
                    end
                    STOP: begin
                        state_d = IDLE;
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        perr_d  = par_en_q && (par_rx_q != ((^shift_q) ^ par_odd_q));
                        ferr_d  = !sync2_q;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= IDLE;
            ovs_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_rx_q  <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rx_uart;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            ovs_q     <= ovs_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_rx_q  <= par_rx_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_valid      = valid_q;
    assign rx_data       = data_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_busy       = (state_q != IDLE);

endmodule

// File: rtl/uart_xcvr.sv
// UART transceiver top: oversample tick dividers, transmit FSM, and the receive sub-module.
//   state  | meaning
//   IDLE   | tx_ready high, line idle high
//   START  | driving start bit
//   DATA   | shifting DATA_W bits, LSB first
//   PARITY | driving latched parity bit
//   STOP   | driving 1 or 2 stop bits
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OVS     = 16,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_uart,
    input  logic              rx_uart,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              tx_busy,
    output logic              rx_busy
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OVS_W = $clog2(OVS);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DIV_W-1:0]  tx_div_q, tx_div_d, rx_div_q, rx_div_d;
    logic              tx_tick, rx_tick, rx_restart, tx_start;
    uart_state_e       tx_state_q, tx_state_d;
    logic [OVS_W-1:0]  tx_ovs_q, tx_ovs_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_par_q, tx_par_d;
    logic              tx_par_en_q, tx_par_en_d;
    logic              tx_stop2_q, tx_stop2_d;
    logic              tx_uart_q, tx_uart_d;

    // Each path restarts its own divider so bit periods are exact in clk cycles.
    assign tx_tick = (tx_div_q == '0);
    assign rx_tick = (rx_div_q == '0);

    always_comb begin
        tx_div_d = tx_div_q - 1'b1;
        if (tx_start || tx_tick) tx_div_d = DIV_W'(CLK_DIV - 1);
        rx_div_d = rx_div_q - 1'b1;
        if (rx_restart || rx_tick) rx_div_d = DIV_W'(CLK_DIV - 1);
    end

    assign tx_ready = (tx_state_q == IDLE) && !reset;
    assign tx_start = tx_valid && tx_ready;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_ovs_d    = tx_ovs_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_par_en_d = tx_par_en_q;
        tx_stop2_d  = tx_stop2_q;
        tx_uart_d   = tx_uart_q;
        if (tx_state_q == IDLE) begin
            tx_uart_d = 1'b1;
            if (tx_start) begin
                tx_state_d  = START;
                tx_uart_d   = 1'b0;
                tx_ovs_d    = OVS_W'(OVS - 1);
                tx_shift_d  = tx_data;
                tx_par_d    = (^tx_data) ^ (parity_mode == PAR_ODD);
                tx_par_en_d = par_enabled(parity_mode);
                tx_stop2_d  = stop2;
            end
        end else if (tx_tick) begin
            if (tx_ovs_q != '0) begin
                tx_ovs_d = tx_ovs_q - 1'b1;
            end else begin
                tx_ovs_d = OVS_W'(OVS - 1);
                case (tx_state_q)
                    START: begin
                        tx_state_d = DATA;
                        tx_uart_d  = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = BIT_W'(DATA_W - 1);
                    end
                    DATA: begin
                        if (tx_bit_q != '0) begin
                            tx_bit_d   = tx_bit_q - 1'b1;
                            tx_uart_d  = tx_shift_q[0];
                            tx_shift_d = tx_shift_q >> 1;
                        end else if (tx_par_en_q) begin
                            tx_state_d = PARITY;
                            tx_uart_d  = tx_par_q;
                        end else begin
                            tx_state_d = STOP;
                            tx_uart_d  = 1'b1;
                            tx_bit_d   = BIT_W'(tx_stop2_q);
                        end
                    end
                    PARITY: begin
                        tx_state_d = STOP;
                        tx_uart_d  = 1'b1;
                        tx_bit_d   = BIT_W'(tx_stop2_q);
                    end
                    STOP: begin
                        if (tx_bit_q != '0) tx_bit_d = tx_bit_q - 1'b1;
                        else tx_state_d = IDLE;
                    end
                    default: begin
                        tx_state_d = IDLE;
                        tx_uart_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_div_q    <= '0;
            rx_div_q    <= '0;
            tx_state_q  <= IDLE;
            tx_ovs_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            tx_par_en_q <= 1'b0;
            tx_stop2_q  <= 1'b0;
            tx_uart_q   <= 1'b1;
        end else begin
            tx_div_q    <= tx_div_d;
            rx_div_q    <= rx_div_d;
            tx_state_q  <= tx_state_d;
            tx_ovs_q    <= tx_ovs_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            tx_par_en_q <= tx_par_en_d;
            tx_stop2_q  <= tx_stop2_d;
            tx_uart_q   <= tx_uart_d;
        end
    end

    assign tx_uart = tx_uart_q;
    assign tx_busy = (tx_state_q != IDLE);

    uart_rx #(
        .DATA_W (DATA_W),
        .OVS    (OVS)
    ) u_rx (
        .clk           (clk),
        .reset         (reset),
        .tick          (rx_tick),
        .parity_mode   (parity_mode),
        .rx_uart       (rx_uart),
        .restart       (rx_restart),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_busy       (rx_busy)
    );

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: loopback vector table plus hand-built RX and reset sequences.
module tb_uart_xcvr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, stop2, tx_valid, tx_ready, tx_uart, rx_uart, rx_drv, loop_en;
    logic       rx_valid, rx_parity_err, rx_frame_err, tx_busy, rx_busy;
    logic [1:0] parity_mode;
    logic [7:0] tx_data, rx_data;
    assign rx_uart = loop_en ? tx_uart : rx_drv;

    uart_xcvr #(.DATA_W(8), .OVS(16), .CLK_DIV(1)) u_dut (
        .clk(clk), .reset(reset), .parity_mode(parity_mode), .stop2(stop2),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_uart(tx_uart),
        .rx_uart(rx_uart), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .tx_busy(tx_busy), .rx_busy(rx_busy)
    );

    logic       reset2, tx_valid2, tx_ready2, tx_uart2, rx_valid2, perr2, ferr2, tx_busy2, rx_busy2;
    logic [6:0] tx_data2, rx_data2;
    logic       rx2 = 1'b1;

    uart_xcvr #(.DATA_W(7), .OVS(16), .CLK_DIV(3)) u_dut2 (
        .clk(clk), .reset(reset2), .parity_mode(2'b00), .stop2(1'b0),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data2), .tx_uart(tx_uart2),
        .rx_uart(rx2), .rx_valid(rx_valid2), .rx_data(rx_data2),
        .rx_parity_err(perr2), .rx_frame_err(ferr2),
        .tx_busy(tx_busy2), .rx_busy(rx_busy2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Receive monitor: captures the frame presented alongside each rx_valid pulse.
    int         rxv_cnt = 0;
    logic [7:0] rx_last = '0;
    logic       perr_last = 1'b0, ferr_last = 1'b0, busy_seen = 1'b0;
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rx_last   = rx_data;
            perr_last = rx_parity_err;
            ferr_last = rx_frame_err;
        end
        if (rx_busy) busy_seen = 1'b1;
    end

    function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic hp,
                                             input logic p, input logic sb);
        logic [11:0] b;
        b      = 12'hFFF;
        b[0]   = 1'b0;
        b[8:1] = d;
        if (hp) begin
            b[9]  = p;
            b[10] = sb;
        end else begin
            b[9] = sb;
        end
        return b;
    endfunction

    task automatic drive_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] pm;
        logic       s2;
        logic       par_en;
        logic       par;
        int         len;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 160};
        vt[1] = '{8'h3C, 2'b01, 1'b1, 1'b1, 1'b0, 192};
        vt[2] = '{8'h81, 2'b10, 1'b0, 1'b1, 1'b1, 176};
        vt[3] = '{8'hFF, 2'b01, 1'b0, 1'b1, 1'b0, 176};
        vt[4] = '{8'h00, 2'b10, 1'b1, 1'b1, 1'b1, 192};
        vt[5] = '{8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 160};
        vt[6] = '{8'h01, 2'b01, 1'b0, 1'b1, 1'b1, 176};

        reset = 1'b1; reset2 = 1'b1; parity_mode = 2'b00; stop2 = 1'b0;
        tx_valid = 1'b0; tx_data = '0; rx_drv = 1'b1; loop_en = 1'b0;
        tx_valid2 = 1'b0; tx_data2 = '0;
        repeat (3) @(negedge clk);
        check("reset_tx_uart", tx_uart, 1'b1);
        check("reset_tx_ready", tx_ready, 1'b0);
        check("reset_busy", {tx_busy, rx_busy}, 2'b00);
        check("reset_rx_outs", {rx_valid, rx_data, rx_parity_err, rx_frame_err}, 0);
        reset = 1'b0; reset2 = 1'b0;
        @(negedge clk);
        check("idle_tx_ready", tx_ready, 1'b1);

        // Loopback vector table
        for (int v = 0; v < 7; v++) begin
            logic [11:0] fb;
            int          nb, len, first_bad;
            fb = mk_frame(vt[v].data, vt[v].par_en, vt[v].par, 1'b1);
            nb = vt[v].len / 16;
            len = -1;
            first_bad = -1;
            parity_mode = vt[v].pm;
            loop_en = 1'b1;
            rxv_cnt = 0;
            @(negedge clk);
            tx_data = vt[v].data; stop2 = vt[v].s2; tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0; tx_data = ~vt[v].data; stop2 = ~vt[v].s2;
            for (int c = 0; c < 400; c++) begin
                if (tx_ready) begin
                    len = c;
                    break;
                end
                if (first_bad < 0 && (c / 16 >= nb || tx_uart !== fb[c/16])) first_bad = c;
                @(negedge clk);
            end
            check($sformatf("v%0d_tx_len", v), len, vt[v].len);
            check($sformatf("v%0d_tx_wave_first_bad_cycle", v), first_bad, 32'hFFFF_FFFF);
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_rx_count", v), rxv_cnt, 1);
            check($sformatf("v%0d_rx_data", v), rx_last, vt[v].data);
            check($sformatf("v%0d_rx_errs", v), {perr_last, ferr_last}, 2'b00);
            loop_en = 1'b0;
        end

        // 0x81, odd parity, parity bit sent wrong
        parity_mode = 2'b10; rxv_cnt = 0;
        drive_bits(mk_frame(8'h81, 1'b1, 1'b0, 1'b1), 11);
        repeat (10) @(negedge clk);
        check("perr_count", rxv_cnt, 1);
        check("perr_data", rx_last, 8'h81);
        check("perr_flags", {perr_last, ferr_last}, 2'b10);

        // Short low glitch on an idle line
        parity_mode = 2'b00; rxv_cnt = 0; busy_seen = 1'b0;
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_count", rxv_cnt, 0);
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_busy_end", rx_busy, 1'b0);

        // Stop bit low, line stays low, then recovers and a clean frame follows
        rxv_cnt = 0;
        drive_bits(mk_frame(8'h55, 1'b0, 1'b0, 1'b0), 10);
        repeat (16) @(negedge clk);
        check("ferr_count", rxv_cnt, 1);
        check("ferr_data", rx_last, 8'h55);
        check("ferr_flag_held", rx_frame_err, 1'b1);
        rx_drv = 1'b1;
        repeat (32) @(negedge clk);
        check("ferr_no_false_start", rxv_cnt, 1);
        drive_bits(mk_frame(8'h12, 1'b0, 1'b0, 1'b1), 10);
        repeat (10) @(negedge clk);
        check("recover_count", rxv_cnt, 2);
        check("recover_data", rx_last, 8'h12);
        check("recover_flags", {perr_last, ferr_last}, 2'b00);

        // Reset in the middle of an RX frame discards it
        rxv_cnt = 0;
        rx_drv = 1'b0;
        repeat (48) @(negedge clk);
        reset = 1'b1; rx_drv = 1'b1;
        repeat (2) @(negedge clk);
        check("rx_abort_busy", rx_busy, 1'b0);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("rx_abort_count", rxv_cnt, 0);

        // CLK_DIV=3, DATA_W=7: reset 100 clk into a TX frame
        check("d2_ready_idle", tx_ready2, 1'b1);
        tx_data2 = 7'h00; tx_valid2 = 1'b1;
        @(negedge clk);
        tx_valid2 = 1'b0;
        repeat (99) @(negedge clk);
        check("d2_mid_frame_low", tx_uart2, 1'b0);
        check("d2_mid_frame_busy", tx_busy2, 1'b1);
        reset2 = 1'b1;
        @(negedge clk);
        check("d2_reset_tx_uart", tx_uart2, 1'b1);
        check("d2_reset_ready_busy", {tx_ready2, tx_busy2}, 2'b00);
        check("d2_reset_rx_outs", {rx_valid2, rx_data2, perr2, ferr2, rx_busy2}, 0);
        reset2 = 1'b0;
        @(negedge clk);
        check("d2_ready_after_reset", tx_ready2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
